// File: rtl/servo_pwm_capture_if.sv
// Bundles the sampled PWM line and the measurement results of servo_pwm_capture.
// The master modport is the capture block; the slave modport is the line driver / result consumer.
interface servo_pwm_capture_if #(
   parameter int CNT_W = 21
);
   logic             pwm_in;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] period;
   logic [1:0]       code;
   logic             valid;
   logic             err;
   logic             lost;

   modport master (
      input  pwm_in,
      output width, period, code, valid, err, lost
   );

   modport slave (
      output pwm_in,
      input  width, period, code, valid, err, lost
   );
endinterface

// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures high width and rise-to-rise period of pwm_in in clock
// cycles, classifies the width against the two generator codes and flags signal loss.
module servo_pwm_capture #(
   parameter int CNT_W      = 21,
   parameter int PERIOD_MIN = 900_000,
   parameter int PERIOD_MAX = 1_100_000,
   parameter int WIDTH_MAX  = 150_000,
   parameter int W0         = 125_000,
   parameter int W1         = 107_500,
   parameter int TOL        = 2_500,
   parameter int TIMEOUT    = 2_000_000
) (
   input  logic                clk,
   input  logic                rst,
   servo_pwm_capture_if.master bus
);

   localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] PERIOD_MIN_C = CNT_W'(PERIOD_MIN);
   localparam logic [CNT_W-1:0] PERIOD_MAX_C = CNT_W'(PERIOD_MAX);
   localparam logic [CNT_W-1:0] WIDTH_MAX_C  = CNT_W'(WIDTH_MAX);
   localparam logic [CNT_W-1:0] W0_C         = CNT_W'(W0);
   localparam logic [CNT_W-1:0] W1_C         = CNT_W'(W1);
   localparam logic [CNT_W-1:0] TOL_C        = CNT_W'(TOL);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   // Compare-then-subtract so the difference never wraps.
   function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      if (a >= b) begin
         abs_diff = a - b;
      end else begin
         abs_diff = b - a;
      end
   endfunction

   logic             sync1_r, sync2_r, hist_r;
   logic             rise_s, fall_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] width_r;
   state_t           state_r, state_nx_s;
   logic             capture_s, publish_s, lose_s;
   logic             err_nx_s;
   logic [1:0]       code_nx_s;
   logic [CNT_W-1:0] width_out_r, period_out_r;
   logic [1:0]       code_out_r;
   logic             valid_out_r, err_out_r, lost_out_r;

   // Two-flop synchronizer plus history flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         hist_r  <= 1'b0;
      end else begin
         sync1_r <= bus.pwm_in;
         sync2_r <= sync1_r;
         hist_r  <= sync2_r;
      end
   end

   assign rise_s = sync2_r & ~hist_r;
   assign fall_s = ~sync2_r & hist_r;

   // Cycle counter: restarts at 1 on every rise so the count at an edge equals elapsed cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (rise_s) begin
         cnt_r <= CNT_W'(1);
      end else if (cnt_r != TIMEOUT_C) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; an edge always takes priority over the timeout.
   always_comb begin
      state_nx_s = state_r;
      capture_s  = 1'b0;
      publish_s  = 1'b0;
      lose_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (rise_s) begin
               state_nx_s = HIGH;
            end else begin
               state_nx_s = IDLE;
            end
         end
         HIGH: begin
            if (fall_s) begin
               state_nx_s = LOW;
               capture_s  = 1'b1;
            end else if (cnt_r == TIMEOUT_C) begin
               state_nx_s = IDLE;
               lose_s     = 1'b1;
            end else begin
               state_nx_s = HIGH;
            end
         end
         LOW: begin
            if (rise_s) begin
               state_nx_s = HIGH;
               publish_s  = 1'b1;
            end else if (cnt_r == TIMEOUT_C) begin
               state_nx_s = IDLE;
               lose_s     = 1'b1;
            end else begin
               state_nx_s = LOW;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Captured high time, held until the next fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width_r <= {CNT_W{1'b0}};
      end else if (capture_s) begin
         width_r <= cnt_r;
      end else begin
         width_r <= width_r;
      end
   end

   // Classification uses cnt_r directly as the period: it is the closing rise-to-rise count.
   always_comb begin
      err_nx_s  = (cnt_r < PERIOD_MIN_C) | (cnt_r > PERIOD_MAX_C) | (width_r > WIDTH_MAX_C);
      code_nx_s = 2'b00;
      if (err_nx_s) begin
         code_nx_s = 2'b00;
      end else if (abs_diff(width_r, W0_C) <= TOL_C) begin
         code_nx_s = 2'b01;
      end else if (abs_diff(width_r, W1_C) <= TOL_C) begin
         code_nx_s = 2'b10;
      end else begin
         code_nx_s = 2'b00;
      end
   end

   // Registered result outputs; loss keeps the last published measurement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width_out_r  <= {CNT_W{1'b0}};
         period_out_r <= {CNT_W{1'b0}};
         code_out_r   <= 2'b00;
         err_out_r    <= 1'b0;
         valid_out_r  <= 1'b0;
         lost_out_r   <= 1'b0;
      end else begin
         valid_out_r <= publish_s;
         if (publish_s) begin
            width_out_r  <= width_r;
            period_out_r <= cnt_r;
            code_out_r   <= code_nx_s;
            err_out_r    <= err_nx_s;
            lost_out_r   <= 1'b0;
         end else if (lose_s) begin
            lost_out_r   <= 1'b1;
         end else begin
            lost_out_r   <= lost_out_r;
         end
      end
   end

   assign bus.width  = width_out_r;
   assign bus.period = period_out_r;
   assign bus.code   = code_out_r;
   assign bus.err    = err_out_r;
   assign bus.valid  = valid_out_r;
   assign bus.lost   = lost_out_r;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Self-checking bench for servo_pwm_capture using scaled-down timing parameters.
// Expected measurements are queued as each period is driven and checked on every valid.
module tb_servo_pwm_capture;

   localparam int CW   = 13;
   localparam int PMIN = 1800;
   localparam int PMAX = 2200;
   localparam int WMAX = 300;
   localparam int W0   = 250;
   localparam int W1   = 215;
   localparam int TOL  = 5;
   localparam int TO   = 4000;
   localparam int P    = 2000;

   typedef struct {
      logic [CW-1:0] w;
      logic [CW-1:0] p;
      logic [1:0]    code;
      logic          err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];
   logic prev_valid = 1'b0;

   servo_pwm_capture_if #(.CNT_W(CW)) bus ();

   servo_pwm_capture #(
      .CNT_W(CW), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX), .WIDTH_MAX(WMAX),
      .W0(W0), .W1(W1), .TOL(TOL), .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every valid must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.valid && prev_valid) begin
            total++; bad++;
            $display("FAIL valid_one_cycle valid=1 on two consecutive cycles, required single cycle");
         end
         if (bus.valid) begin
            if (sb_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_valid width=%0d period=%0d, required no valid", bus.width, bus.period);
            end else begin
               e = sb_q.pop_front();
               total += 5;
               if (bus.width !== e.w) begin
                  bad++; $display("FAIL width got=%0d exp=%0d", bus.width, e.w);
               end
               if (bus.period !== e.p) begin
                  bad++; $display("FAIL period got=%0d exp=%0d", bus.period, e.p);
               end
               if (bus.code !== e.code) begin
                  bad++; $display("FAIL code got=%b exp=%b (width=%0d period=%0d)", bus.code, e.code, e.w, e.p);
               end
               if (bus.err !== e.err) begin
                  bad++; $display("FAIL err got=%b exp=%b (width=%0d period=%0d)", bus.err, e.err, e.w, e.p);
               end
               if (bus.lost !== 1'b0) begin
                  bad++; $display("FAIL lost_at_valid got=%b exp=0", bus.lost);
               end
            end
         end
         prev_valid <= bus.valid;
      end else begin
         prev_valid <= 1'b0;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One PWM period starting with a rise; pub queues its measurement for the closing rise.
   task automatic drive_period(input int h, input int p, input bit pub,
                               input logic [1:0] c, input logic e);
      exp_t x;
      if (pub) begin
         x.w = CW'(h); x.p = CW'(p); x.code = c; x.err = e;
         sb_q.push_back(x);
      end
      bus.pwm_in = 1'b1;
      wait_cyc(h);
      bus.pwm_in = 1'b0;
      wait_cyc(p - h);
   endtask

   task automatic check_all_zero(input string name);
      total++;
      if (bus.width !== '0 || bus.period !== '0 || bus.code !== 2'b00 ||
          bus.err !== 1'b0 || bus.valid !== 1'b0 || bus.lost !== 1'b0) begin
         bad++;
         $display("FAIL %s w=%0d p=%0d code=%b err=%b valid=%b lost=%b, required all 0",
                  name, bus.width, bus.period, bus.code, bus.err, bus.valid, bus.lost);
      end
   endtask

   task automatic test_reset();
      bus.pwm_in = 1'b0;
      rst = 1'b1;
      #3;
      check_all_zero("reset_outputs");
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(10);
      check_all_zero("after_release");
   endtask

   task automatic test_stream();
      for (int i = 0; i < 3; i++) drive_period(W0, P, 1'b1, 2'b01, 1'b0);
   endtask

   task automatic test_codes();
      drive_period(W1, P, 1'b1, 2'b10, 1'b0);
      drive_period(W1 + TOL + 1, P, 1'b1, 2'b00, 1'b0);
   endtask

   task automatic test_tolerance();
      drive_period(W0 - TOL, P, 1'b1, 2'b01, 1'b0);
      drive_period(W0 + TOL, P, 1'b1, 2'b01, 1'b0);
      drive_period(W0 - TOL - 1, P, 1'b1, 2'b00, 1'b0);
   endtask

   task automatic test_range();
      drive_period(W0, PMIN - 1, 1'b1, 2'b00, 1'b1);
      drive_period(W0, PMAX, 1'b1, 2'b01, 1'b0);
      drive_period(WMAX + 1, P, 1'b1, 2'b00, 1'b1);
   endtask

   // Rise closes the last range period, then the line stays low until lost.
   task automatic test_lost();
      int n = 0;
      bus.pwm_in = 1'b1;
      while (bus.lost !== 1'b1 && n < 2 * TO) begin
         wait_cyc(1);
         n++;
         if (n == W0) bus.pwm_in = 1'b0;
      end
      total++;
      if (n != TO + 3) begin
         bad++; $display("FAIL lost_latency got=%0d cycles exp=%0d (lost=%b)", n, TO + 3, bus.lost);
      end
      total++;
      if (bus.width !== CW'(WMAX + 1) || bus.err !== 1'b1 || bus.code !== 2'b00) begin
         bad++;
         $display("FAIL hold_after_lost w=%0d err=%b code=%b, required w=%0d err=1 code=00",
                  bus.width, bus.err, bus.code, WMAX + 1);
      end
   endtask

   task automatic test_recovery();
      exp_t x;
      x.w = CW'(W0); x.p = CW'(P); x.code = 2'b01; x.err = 1'b0;
      sb_q.push_back(x);
      bus.pwm_in = 1'b1;
      wait_cyc(20);
      total++;
      if (bus.lost !== 1'b1) begin
         bad++; $display("FAIL lost_after_arm got=%b exp=1", bus.lost);
      end
      wait_cyc(W0 - 20);
      bus.pwm_in = 1'b0;
      wait_cyc(P - W0);
   endtask

   task automatic test_reset_mid_high();
      bus.pwm_in = 1'b1;
      wait_cyc(10);
      total++;
      if (bus.lost !== 1'b0) begin
         bad++; $display("FAIL lost_cleared got=%b exp=0", bus.lost);
      end
      wait_cyc(W0 / 2 - 10);
      rst = 1'b1;
      #2;
      check_all_zero("reset_mid_high");
      total++;
      if (sb_q.size() != 0) begin
         bad++; $display("FAIL pending_at_reset got=%0d entries exp=0", sb_q.size());
      end
      wait_cyc(3);
      bus.pwm_in = 1'b0;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(50);
      drive_period(W0, P, 1'b1, 2'b01, 1'b0);
      drive_period(W1, P, 1'b1, 2'b10, 1'b0);
   endtask

   // Behavioural generator loopback: sign selects the W1 pulse, otherwise W0.
   task automatic test_loopback();
      bit sign_seq[3] = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         if (sign_seq[i]) drive_period(W1, P, 1'b1, 2'b10, 1'b0);
         else             drive_period(W0, P, 1'b1, 2'b01, 1'b0);
      end
      drive_period(W0, P, 1'b0, 2'b00, 1'b0);
      total++;
      if (sb_q.size() != 0) begin
         bad++; $display("FAIL missing_valid got=%0d unpublished entries exp=0", sb_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.pwm_in = 1'b0;
      test_reset();
      test_stream();
      test_codes();
      test_tolerance();
      test_range();
      test_lost();
      test_recovery();
      test_reset_mid_high();
      test_loopback();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
